calc_seq: RTL and testbench
===========================

# calc_seq

Parametrised sequential decimal calculator: the keypad-driven successor of the team's 8-digit calculator. It accepts one 4-bit keypad command per cycle through a valid handshake and supports add, subtract, multiply and divide on `NDIG`-digit unsigned operands. Multiply, divide and binary-to-BCD conversion are multi-cycle and reported through `status`. Digits are scanned out one per cycle on `data`/`pos` for the 7-segment display driver.

## Interface
- `NDIG`, default 8: number of decimal display digits (1..15).
- `W`, default 27: binary operand width; must satisfy 2^W > 10^NDIG − 1.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high; one clock; polarity and synchronicity fixed.
- `cmd`  in  4: command code.
  - 0–9: digit.
  - 10: add; 11: sub; 12: mul; 13: div.
  - 14: equals.
  - 15: backspace.
- `cmd_valid`  in  1: `cmd` is presented this cycle.
- `status`  out  2: 2'b00 error, 2'b01 busy, 2'b10 ready; 2'b11 never driven.
- `data`  out  4: BCD digit at index `pos`.
- `pos`  out  4: display digit index, 0 = least significant.

## Operation
- Accept rule: a command is consumed only when `cmd_valid`=1 and `status`=ready. Commands offered at any other time are dropped, never queued.
- Registers:
  - `val`: binary entry/result value, W bits.
  - `opA`: W bits.
  - `op`: pending operation code.
  - `bcd`: NDIG×4 display digits.
- States and transitions:
  - ENTER_A, digit: accepted only if `val`·10+d ≤ 10^NDIG−1, otherwise ignored.
  - ENTER_A, backspace: `val`←`val`/10.
  - ENTER_A, operator: `opA`←`val`, `op`←cmd, `val`←0, go to ENTER_B.
  - ENTER_A, equals: ignored.
  - ENTER_A, chaining: when ENTER_A was entered from CONVERT (a result is displayed), the first digit restarts entry from 0. An operator instead chains the result as `opA`.
  - ENTER_B: digits and backspace behave as in ENTER_A. Equals goes to EXEC. Any operator code (10–13) goes to ERROR.
  - EXEC, add and sub: 1 cycle.
    - Sub with `opA` < `val` → ERROR.
  - EXEC, mul: shift-add, exactly W cycles.
  - EXEC, div: restoring division, exactly W cycles; quotient only.
    - Divisor 0 → ERROR on the first EXEC cycle.
  - EXEC, overflow: a result > 10^NDIG−1 → ERROR. Mul keeps a 2W-bit product internally for this check.
  - EXEC exit: `val`←result, go to CONVERT.
  - CONVERT: double-dabble `val`→`bcd`, exactly W cycles, then go to ENTER_A (result displayed).
  - ERROR: sticky until `reset`; `val` and `bcd` are cleared.
- Entry display: during ENTER_A/ENTER_B, `bcd` is updated in the same edge as `val`.
  - Digit: BCD shift left, d inserted at index 0.
  - Backspace: BCD shift right, 0 inserted at the top digit.
  - No CONVERT is needed for entry.
- Status mapping: EXEC and CONVERT → busy; ERROR → error; otherwise → ready.
- Display scan:
  - When `status` ≠ busy: `pos` increments every cycle and wraps NDIG−1→0.
  - `data` = `bcd[pos]`, combinational from registers.
  - While busy: `pos` holds and `data` = 0.
  - In ERROR: `data` = 0 and `pos` keeps scanning.

## Timing
- Reset values: `status`=2'b10, `data`=0, `pos`=0, state ENTER_A, all registers 0.
- `reset` asserted mid-EXEC or mid-CONVERT aborts the operation; reset values appear the cycle after the `reset` edge.
- Digit or backspace accepted at edge t: the new `bcd` is visible from t+1.
- Equals accepted at edge t: `status`=busy from t+1.
- Busy duration before `status`=ready with the result in `bcd`:
  - add/sub: 1+W cycles.
  - mul/div: 2W cycles.
- Error detected in EXEC cycle k: `status`=error from the next cycle.
- Simultaneous `cmd_valid` on the cycle status returns to ready: that command is accepted.
- Simultaneous `reset` and `cmd_valid`: `reset` wins and the command is dropped.
- Backspace at `val`=0 leaves 0.

## Test plan
- Mul with NDIG=8, W=27: enter 1234, 12, 5678, 14 → busy exactly 54 cycles, then ready with `bcd` = 0,7,0,0,6,6,5,2 (7006652); `pos` scans 0..7 and wraps.
- Div with chaining: enter 100, 13, 7, 14 → 14. Then 10, 1, 14 → 15.
- Error paths:
  - 5, 11, 9, 14 → `status`=00.
  - 8, 13, 0, 14 → `status`=00.
  - 99999999, 10, 1, 14 → `status`=00.
  - Each error persists until `reset`.
- Entry limits:
  - Nine digit presses (1..9) → display 12345678, ninth ignored.
  - 15 twice → 123456; 15 at 0 → 0.
- Handshake:
  - `cmd_valid` pulses during busy are dropped and the result is unchanged.
  - `cmd_valid`=0 with cmd=5 has no effect.
  - Operator 10 in ENTER_B → error.
- Reset mid-mul (cycle 10 of EXEC) → next cycle `status`=10, `data`=0, `pos`=0; a fresh 2, 10, 3, 14 → 5.

Source files
------------

// File: rtl/calc_seq.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq
// Purpose  : Keypad-driven sequential decimal calculator. One 4-bit command
//            per cycle (digits 0-9, + - * /, =, backspace) is accepted while
//            the unit is ready. Mul/div run as W-cycle shift-add / restoring
//            division; results are converted to BCD by a W-cycle
//            double-dabble. Display digits are scanned out one per cycle.
// Ports    : clock     - rising-edge clock
//            reset     - synchronous active-high reset
//            cmd       - command code (0-9 digit, 10 add, 11 sub, 12 mul,
//                        13 div, 14 equals, 15 backspace)
//            cmd_valid - cmd is presented this cycle
//            status    - 00 error, 01 busy, 10 ready
//            data      - BCD digit at display index pos (0 while busy/error)
//            pos       - display digit index, 0 = least significant
// Revision : 1.0 - initial release
// ============================================================================
module calc_seq #(
   parameter int NDIG = 8,
   parameter int W    = 27
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] cmd,
   input  logic       cmd_valid,
   output logic [1:0] status,
   output logic [3:0] data,
   output logic [3:0] pos
);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0]      MAX64    = pow10(NDIG) - 64'd1;
   localparam logic [W-1:0]     MAX_W    = W'(MAX64);
   localparam logic [W+3:0]     MAX_E    = (W+4)'(MAX64);
   localparam logic [2*W-1:0]   MAX_P    = (2*W)'(MAX64);
   localparam int               CW       = $clog2(W + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(W - 1);
   localparam int               BW       = 4 * NDIG;
   localparam logic [3:0]       POS_LAST = 4'(NDIG - 1);

   localparam logic [1:0] ST_ERR   = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_READY = 2'b10;

   localparam logic [3:0] CMD_ADD  = 4'd10;
   localparam logic [3:0] CMD_SUB  = 4'd11;
   localparam logic [3:0] CMD_MUL  = 4'd12;
   localparam logic [3:0] CMD_EQ   = 4'd14;
   localparam logic [3:0] CMD_BKSP = 4'd15;

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_EXEC    = 3'd2,
      S_CONVERT = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t            state;
   logic              shown;     // ENTER_A holds a computed result
   logic [W-1:0]      val;
   logic [W-1:0]      opa;
   logic [3:0]        op;
   logic [BW-1:0]     bcd;
   logic [CW-1:0]     cnt;
   logic [2*W-1:0]    prod;
   logic [2*W-1:0]    mcand;
   logic [W-1:0]      mplier;
   logic [W-1:0]      rem;
   logic [W-1:0]      quo;
   logic [W-1:0]      bin;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic              is_digit;
   logic [W+3:0]      digit_ext;
   logic              digit_ok;
   logic [W:0]        sum;
   logic [2*W-1:0]    prod_next;
   logic [W:0]        rem_sh;
   logic [W:0]        rem_diff;
   logic              rem_ge;
   logic [W-1:0]      rem_next;
   logic [W-1:0]      quo_next;
   logic [BW-1:0]     dd_adj;
   logic [BW-1:0]     dd_next;
   logic [3:0]        scan_digit;

   assign is_digit  = (cmd <= 4'd9);
   // val*10 < 2^(W+4), so the extended product never wraps.
   assign digit_ext = ({4'b0000, val} * (W+4)'(10)) + (W+4)'(cmd);
   assign digit_ok  = (digit_ext <= MAX_E);

   assign sum       = {1'b0, opa} + {1'b0, val};
   assign prod_next = mplier[0] ? (prod + mcand) : prod;

   // Restoring division step: a clear borrow bit means the trial
   // subtraction succeeded and the quotient bit is 1.
   assign rem_sh    = {rem, quo[W-1]};
   assign rem_diff  = rem_sh - {1'b0, val};
   assign rem_ge    = ~rem_diff[W];
   assign rem_next  = rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
   assign quo_next  = {quo[W-2:0], rem_ge};

   // Double-dabble: add 3 to every digit >= 5, then shift in the next bit.
   always_comb begin
      dd_adj = bcd;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end
   assign dd_next = {dd_adj[BW-2:0], bin[W-1]};

   always_comb begin
      scan_digit = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (pos == 4'(i)) scan_digit = bcd[4*i +: 4];
      end
   end

   always_comb begin
      case (state)
         S_EXEC, S_CONVERT: status = ST_BUSY;
         S_ERROR:           status = ST_ERR;
         default:           status = ST_READY;
      endcase
   end

   assign data = (status == ST_READY) ? scan_digit : 4'd0;

   // ---------------------------------------------------------------------
   // Main sequencer
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_ENTER_A;
         shown  <= 1'b0;
         val    <= '0;
         opa    <= '0;
         op     <= 4'd0;
         bcd    <= '0;
         pos    <= 4'd0;
         cnt    <= '0;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         rem    <= '0;
         quo    <= '0;
         bin    <= '0;
      end else begin
         if (status != ST_BUSY) pos <= (pos == POS_LAST) ? 4'd0 : pos + 4'd1;

         case (state)
            S_ENTER_A, S_ENTER_B: begin
               if (cmd_valid) begin
                  if (is_digit) begin
                     if ((state == S_ENTER_A) && shown) begin
                        // First digit after a result starts a new number.
                        val   <= W'(cmd);
                        bcd   <= BW'(cmd);
                        shown <= 1'b0;
                     end else if (digit_ok) begin
                        val <= digit_ext[W-1:0];
                        bcd <= (bcd << 4) | BW'(cmd);
                     end
                  end else if (cmd == CMD_BKSP) begin
                     val   <= val / W'(10);
                     bcd   <= bcd >> 4;
                     shown <= 1'b0;
                  end else if (cmd == CMD_EQ) begin
                     if (state == S_ENTER_B) begin
                        state  <= S_EXEC;
                        cnt    <= '0;
                        prod   <= '0;
                        mcand  <= {{W{1'b0}}, opa};
                        mplier <= val;
                        rem    <= '0;
                        quo    <= opa;
                     end
                  end else if (state == S_ENTER_A) begin
                     opa   <= val;
                     op    <= cmd;
                     val   <= '0;
                     bcd   <= '0;
                     shown <= 1'b0;
                     state <= S_ENTER_B;
                  end else begin
                     // A second operator before equals is a usage error.
                     state <= S_ERROR;
                     val   <= '0;
                     bcd   <= '0;
                  end
               end
            end

            S_EXEC: begin
               case (op)
                  CMD_ADD: begin
                     if (sum > {1'b0, MAX_W}) begin
                        state <= S_ERROR;
                        val   <= '0;
                        bcd   <= '0;
                     end else begin
                        val   <= sum[W-1:0];
                        bin   <= sum[W-1:0];
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= S_CONVERT;
                     end
                  end
                  CMD_SUB: begin
                     if (opa < val) begin
                        state <= S_ERROR;
                        val   <= '0;
                        bcd   <= '0;
                     end else begin
                        val   <= opa - val;
                        bin   <= opa - val;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= S_CONVERT;
                     end
                  end
                  CMD_MUL: begin
                     prod   <= prod_next;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                     cnt    <= cnt + CW'(1);
                     if (cnt == CNT_LAST) begin
                        if (prod_next > MAX_P) begin
                           state <= S_ERROR;
                           val   <= '0;
                           bcd   <= '0;
                        end else begin
                           val   <= prod_next[W-1:0];
                           bin   <= prod_next[W-1:0];
                           bcd   <= '0;
                           cnt   <= '0;
                           state <= S_CONVERT;
                        end
                     end
                  end
                  default: begin
                     if ((cnt == '0) && (val == '0)) begin
                        state <= S_ERROR;
                        val   <= '0;
                        bcd   <= '0;
                     end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + CW'(1);
                        // Quotient never exceeds the dividend, so no
                        // overflow check is needed here.
                        if (cnt == CNT_LAST) begin
                           val   <= quo_next;
                           bin   <= quo_next;
                           bcd   <= '0;
                           cnt   <= '0;
                           state <= S_CONVERT;
                        end
                     end
                  end
               endcase
            end

            S_CONVERT: begin
               bcd <= dd_next;
               bin <= bin << 1;
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  state <= S_ENTER_A;
                  shown <= 1'b1;
               end
            end

            default: begin
               state <= S_ERROR;
               val   <= '0;
               bcd   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq
// Purpose  : Self-checking bench for calc_seq. An arithmetic reference model
//            (plain integers) tracks the entry value, pending operand and
//            mode; results, busy durations and the scanned display are
//            compared against it for directed and random key sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_seq;
   localparam int     NDIG = 8;
   localparam int     W    = 27;
   localparam longint MAXV = 64'd99999999;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] cmd = 4'd0;
   logic       cmd_valid = 1'b0;
   logic [1:0] status;
   logic [3:0] data;
   logic [3:0] pos;

   int checks = 0;
   int errors = 0;

   calc_seq #(.NDIG(NDIG), .W(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .status    (status),
      .data      (data),
      .pos       (pos)
   );

   always #5 clock = ~clock;

   // Reference model
   typedef enum int {M_A, M_B, M_ERR} mmode_t;
   mmode_t m_mode;
   longint m_val, m_opa;
   int     m_op;
   bit     m_shown;

   function automatic longint p10(input int n);
      longint r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_A; m_val = 0; m_opa = 0; m_op = 0; m_shown = 0;
   endtask

   // All tasks start and end just after a falling edge.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      chk({tag, "_status"}, 64'(status), 64'd2);
      chk({tag, "_data"},   64'(data),   64'd0);
      chk({tag, "_pos"},    64'(pos),    64'd0);
   endtask

   task automatic send(input logic [3:0] c);
      cmd = c;
      cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   // Scan NDIG+1 cycles: rebuild the displayed number and check that pos
   // advances by one modulo NDIG (the extra sample covers the wrap).
   task automatic check_disp(input string tag);
      logic [63:0] obs;
      bit          scan_ok;
      int          p, prev;
      obs = 0; scan_ok = 1; prev = 0;
      for (int i = 0; i <= NDIG; i++) begin
         p = int'(pos);
         if (i > 0 && p != (prev + 1) % NDIG) scan_ok = 0;
         if (i < NDIG) obs = obs + 64'(data) * 64'(p10(p));
         prev = p;
         @(negedge clock);
      end
      chk(tag, obs, 64'(m_val));
      chk({tag, "_scan"}, 64'(scan_ok), 64'd1);
   endtask

   task automatic press(input logic [3:0] c, input bit pulse);
      bit     err;
      longint res;
      int     n_busy, count;
      send(c);
      if (m_mode == M_ERR) begin
         chk("err_sticky", 64'(status), 64'd0);
      end else if (c <= 9) begin
         if (m_mode == M_A && m_shown) begin m_val = c; m_shown = 0; end
         else if (m_val * 10 + c <= MAXV) m_val = m_val * 10 + c;
         chk("digit_status", 64'(status), 64'd2);
      end else if (c == 15) begin
         m_val = m_val / 10; m_shown = 0;
         chk("bksp_status", 64'(status), 64'd2);
      end else if (c == 14 && m_mode == M_A) begin
         chk("eq_ignored", 64'(status), 64'd2);
      end else if (c == 14) begin
         err = 0; res = 0;
         case (m_op)
            10: begin res = m_opa + m_val; err = res > MAXV; n_busy = err ? 1 : 1 + W; end
            11: begin err = m_opa < m_val; res = m_opa - m_val; n_busy = err ? 1 : 1 + W; end
            12: begin res = m_opa * m_val; err = res > MAXV; n_busy = err ? W : 2 * W; end
            default: begin
               err = (m_val == 0);
               res = err ? 0 : m_opa / m_val;
               n_busy = err ? 1 : 2 * W;
            end
         endcase
         count = 0;
         while (status == 2'b01 && count < 4 * W) begin
            if (pulse) begin
               cmd = 4'($urandom_range(0, 15));
               cmd_valid = 1'($urandom_range(0, 1));
            end
            count++;
            @(negedge clock);
         end
         cmd_valid = 1'b0;
         chk("busy_cycles", 64'(count), 64'(n_busy));
         if (err) begin
            m_mode = M_ERR; m_val = 0;
            chk("exec_err", 64'(status), 64'd0);
         end else begin
            m_mode = M_A; m_val = res; m_shown = 1;
            chk("exec_ready", 64'(status), 64'd2);
         end
      end else if (m_mode == M_A) begin
         m_opa = m_val; m_op = c; m_val = 0; m_mode = M_B; m_shown = 0;
         chk("op_status", 64'(status), 64'd2);
      end else begin
         m_mode = M_ERR; m_val = 0;
         chk("op_in_b_err", 64'(status), 64'd0);
      end
   endtask

   task automatic press_seq(input logic [3:0] s [], input bit pulse);
      foreach (s[i]) press(s[i], pulse);
   endtask

   initial begin
      logic [3:0] seq [];
      int         r;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      do_reset("reset");

      // Multiply 1234 * 5678 with dropped pulses while busy
      seq = '{4'd1, 4'd2, 4'd3, 4'd4};
      press_seq(seq, 1'b0);
      check_disp("entry_1234");
      seq = '{4'd12, 4'd5, 4'd6, 4'd7, 4'd8, 4'd14};
      press_seq(seq, 1'b1);
      chk("mul_result_val", 64'(m_val), 64'd7006652);
      check_disp("mul_disp");

      // Division followed by chaining
      do_reset("reset_div");
      seq = '{4'd1, 4'd0, 4'd0, 4'd13, 4'd7, 4'd14};
      press_seq(seq, 1'b0);
      check_disp("div_disp");
      seq = '{4'd10, 4'd1, 4'd14};
      press_seq(seq, 1'b0);
      check_disp("chain_disp");

      // Error paths, each sticky until reset
      do_reset("reset_e1");
      seq = '{4'd5, 4'd11, 4'd9, 4'd14, 4'd3};
      press_seq(seq, 1'b0);
      check_disp("sub_err_disp");
      do_reset("reset_e2");
      seq = '{4'd8, 4'd13, 4'd0, 4'd14, 4'd14};
      press_seq(seq, 1'b0);
      do_reset("reset_e3");
      seq = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd10, 4'd1, 4'd14, 4'd1};
      press_seq(seq, 1'b0);
      chk("ovf_status", 64'(status), 64'd0);

      // Entry limits
      do_reset("reset_lim");
      seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
      press_seq(seq, 1'b0);
      check_disp("nine_digits");
      seq = '{4'd15, 4'd15};
      press_seq(seq, 1'b0);
      check_disp("bksp_twice");
      do_reset("reset_bk0");
      press(4'd15, 1'b0);
      check_disp("bksp_zero");

      // cmd_valid low has no effect
      cmd = 4'd5;
      repeat (3) @(negedge clock);
      check_disp("valid_low");

      // Second operator in ENTER_B
      seq = '{4'd1, 4'd10, 4'd2, 4'd10};
      press_seq(seq, 1'b0);

      // Reset in the middle of a multiply
      do_reset("reset_mm");
      seq = '{4'd9, 4'd9, 4'd12, 4'd9, 4'd9};
      press_seq(seq, 1'b0);
      send(4'd14);
      repeat (9) @(negedge clock);
      chk("mid_mul_busy", 64'(status), 64'd1);
      do_reset("reset_mid_mul");
      seq = '{4'd2, 4'd10, 4'd3, 4'd14};
      press_seq(seq, 1'b0);
      check_disp("after_abort");

      // Reset and cmd_valid together: reset wins
      seq = '{4'd1, 4'd2};
      press_seq(seq, 1'b0);
      cmd = 4'd5;
      cmd_valid = 1'b1;
      do_reset("reset_with_cmd");
      cmd_valid = 1'b0;
      check_disp("reset_cmd_dropped");

      // Random key sequences against the model
      for (int it = 0; it < 300; it++) begin
         if (m_mode == M_ERR) do_reset("rand_reset");
         r = $urandom_range(0, 99);
         if (r < 55)      press(4'($urandom_range(0, 9)), 1'b1);
         else if (r < 63) press(4'd15, 1'b1);
         else if (r < 78) press(4'($urandom_range(10, 13)), 1'b1);
         else if (r < 92) press(4'd14, 1'b1);
         else begin
            cmd = 4'($urandom_range(0, 15));
            @(negedge clock);
         end
         if (it % 10 == 9) check_disp("rand_disp");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
